// File: rtl/pwm_duty_decoder.sv
// Measures one period of a sampled PWM waveform and reports its high-time
// fraction as a one-hot duty code quantised to WORD_LENGTH levels.
module pwm_duty_decoder #(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pwm_in,
  output logic [WORD_LENGTH-1:0] DC,
  output logic                   dc_valid,
  output logic                   timeout
);

  localparam int ACC_W = COUNT_WIDTH + $clog2(2 * WORD_LENGTH) + 1;
  localparam int LVL_W = $clog2(WORD_LENGTH + 1);
  localparam logic [COUNT_WIDTH-1:0] TO_LAST   = COUNT_WIDTH'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0]       CALC_LAST = LVL_W'(WORD_LENGTH - 1);
  localparam logic [ACC_W-1:0]       SCALE     = ACC_W'(2 * WORD_LENGTH);
  localparam logic [WORD_LENGTH-1:0] DC_FULL   = WORD_LENGTH'(1) << (WORD_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, CALC, DONE} state_t;

  state_t                 state, next_state;
  logic                   sync1, s_in, s_prev, rise;
  logic [COUNT_WIDTH-1:0] idle_cnt, period_cnt, high_cnt;
  logic [ACC_W-1:0]       acc, high_scaled, period2;
  logic [LVL_W-1:0]       level, level_next, calc_cnt;
  logic                   hit, load_edge, load_flat;

  function automatic logic [WORD_LENGTH-1:0] onehot(input logic [LVL_W-1:0] lvl);
    onehot = '0;
    for (int k = 0; k < WORD_LENGTH; k++)
      if (lvl == LVL_W'(k + 1)) onehot[k] = 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      s_in   <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s_in   <= sync1;
      s_prev <= s_in;
    end
  end

  assign rise = s_in & ~s_prev;

  // Threshold t passes when 2*WL*high >= period*(2t-1): a round-half-up divide.
  assign high_scaled = ACC_W'(high_cnt) * SCALE;
  assign period2     = ACC_W'(period_cnt) << 1;
  assign hit         = (high_scaled >= acc);
  assign level_next  = level + LVL_W'(hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise)                     next_state = MEASURE;
          else if (idle_cnt == TO_LAST) next_state = DONE;
        end
        MEASURE: begin
          if (rise)                       next_state = CALC;
          else if (period_cnt >= TO_LAST) next_state = DONE;
        end
        CALC:    if (calc_cnt == CALC_LAST) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    dc_valid  = (state == DONE);
    load_edge = enable && (state == CALC) && (calc_cnt == CALC_LAST);
    load_flat = enable && (next_state == DONE) &&
                ((state == IDLE) || (state == MEASURE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      acc        <= '0;
      level      <= '0;
      calc_cnt   <= '0;
    end else if (!enable) begin
      idle_cnt   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      acc        <= '0;
      level      <= '0;
      calc_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            idle_cnt   <= '0;
            period_cnt <= COUNT_WIDTH'(1);
            high_cnt   <= COUNT_WIDTH'(1);
          end else if (load_flat) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + COUNT_WIDTH'(1);
          end
        end
        MEASURE: begin
          // The closing rise cycle belongs to the next period, so it is not counted.
          if (rise) begin
            acc      <= ACC_W'(period_cnt);
            level    <= '0;
            calc_cnt <= '0;
          end else begin
            period_cnt <= period_cnt + COUNT_WIDTH'(1);
            high_cnt   <= high_cnt + COUNT_WIDTH'(s_in);
          end
        end
        CALC: begin
          level    <= level_next;
          acc      <= acc + period2;
          calc_cnt <= calc_cnt + LVL_W'(1);
        end
        default: begin
          idle_cnt   <= '0;
          period_cnt <= '0;
          high_cnt   <= '0;
          acc        <= '0;
          level      <= '0;
          calc_cnt   <= '0;
        end
      endcase
    end
  end

  // Result registers load on entry to DONE so DC is already valid with the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DC      <= '0;
      timeout <= 1'b0;
    end else if (load_edge) begin
      DC      <= onehot(level_next);
      timeout <= 1'b0;
    end else if (load_flat) begin
      DC      <= s_in ? DC_FULL : '0;
      timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: directed duty table, random
// periods against an arithmetic rounding model, and flat-line/reset/enable cases.
module tb_pwm_duty_decoder;

  localparam int WL = 8;
  localparam int CW = 16;
  localparam int TO = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pwm_in;
  logic [WL-1:0] DC;
  logic          dc_valid;
  logic          timeout;

  pwm_duty_decoder #(.WORD_LENGTH(WL), .COUNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pwm_in   (pwm_in),
    .DC       (DC),
    .dc_valid (dc_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            h;
    int            l;
    logic [WL-1:0] dc;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Pulse monitor, updated by every tick.
  int            cyc;
  bit            seen;
  int            p_cyc;
  logic [WL-1:0] p_dc;
  logic          p_to;
  int            npulse;
  bit            prev_valid;
  bit            dbl;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; seen = 0; p_cyc = 0; p_dc = '0; p_to = 1'b0;
    npulse = 0; prev_valid = 0; dbl = 0;
  endtask

  task automatic tick(input logic v);
    pwm_in = v;
    @(negedge clk);
    cyc++;
    if (dc_valid === 1'b1) begin
      if (prev_valid) dbl = 1;
      if (!seen) begin
        seen  = 1;
        p_cyc = cyc;
        p_dc  = DC;
        p_to  = timeout;
      end
      npulse++;
    end
    prev_valid = (dc_valid === 1'b1);
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Two low cycles, then whole periods of h high / l low until a pulse shows.
  task automatic measure(input int h, input int l, input bit do_reset);
    if (do_reset) apply_reset();
    clear_mon();
    repeat (2) tick(1'b0);
    for (int n = 0; n < 40 && !seen; n++) begin
      repeat (h) tick(1'b1);
      repeat (l) tick(1'b0);
    end
  endtask

  // Reference: level = round-half-up(WL*h/p), reported one-hot.
  function automatic logic [WL-1:0] model_dc(input int h, input int p);
    int lvl;
    lvl = (2 * WL * h + p) / (2 * p);
    if (lvl == 0) return '0;
    return WL'(1) << (lvl - 1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   h, p;

    tbl[0] = '{h: 4,  l: 4,  dc: 8'b0000_1000};
    tbl[1] = '{h: 1,  l: 7,  dc: 8'b0000_0001};
    tbl[2] = '{h: 7,  l: 1,  dc: 8'b0100_0000};
    tbl[3] = '{h: 3,  l: 13, dc: 8'b0000_0010};
    tbl[4] = '{h: 3,  l: 97, dc: 8'h00};
    tbl[5] = '{h: 97, l: 3,  dc: 8'b1000_0000};

    apply_reset();
    @(negedge clk);
    check("reset_dc", DC, 0);
    check("reset_valid", dc_valid, 0);
    check("reset_timeout", timeout, 0);

    // Second rise is tick 3+h+l; two synchroniser stages then WL+1 cycles.
    foreach (tbl[i]) begin
      measure(tbl[i].h, tbl[i].l, 1'b1);
      check($sformatf("tbl%0d_seen", i), seen, 1);
      check($sformatf("tbl%0d_dc", i), p_dc, tbl[i].dc);
      check($sformatf("tbl%0d_timeout", i), p_to, 0);
      check($sformatf("tbl%0d_latency", i), p_cyc, 3 + tbl[i].h + tbl[i].l + 1 + WL + 1);
      check($sformatf("tbl%0d_single", i), dbl, 0);
    end

    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(2, 120));
      h = int'($urandom_range(1, p - 1));
      measure(h, p - h, 1'b1);
      check($sformatf("rand%0d_h%0d_p%0d_dc", i, h, p), seen ? p_dc : 8'hxx, model_dc(h, p));
      check($sformatf("rand%0d_timeout", i), p_to, 0);
    end

    // Flat-high after reset reports full duty with timeout.
    apply_reset();
    clear_mon();
    for (int i = 0; i < 3 * TO && !seen; i++) tick(1'b1);
    check("flat_hi_seen", seen, 1);
    check("flat_hi_time", (p_cyc >= TO - 2) && (p_cyc <= TO + 4), 1);
    check("flat_hi_dc", p_dc, 8'b1000_0000);
    check("flat_hi_timeout", p_to, 1);

    measure(2, 6, 1'b0);
    check("after_flat_dc", p_dc, 8'b0000_0010);
    check("after_flat_timeout", p_to, 0);
    check("after_flat_out_timeout", timeout, 0);

    // Flat-low replaces the previous code with zero.
    clear_mon();
    for (int i = 0; i < 3 * TO && !seen; i++) tick(1'b0);
    check("flat_lo_seen", seen, 1);
    check("flat_lo_dc", p_dc, 0);
    check("flat_lo_timeout", p_to, 1);

    // Reset pulse while the decoder is in CALC aborts the result.
    measure(2, 6, 1'b1);
    check("pre_abort_dc", DC, 8'b0000_0010);
    clear_mon();
    repeat (4) tick(1'b0);
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b0);
    repeat (4) tick(1'b1);
    reset = 1'b0;
    tick(1'b1);
    check("abort_dc_in_reset", DC, 0);
    check("abort_timeout_in_reset", timeout, 0);
    tick(1'b0);
    reset = 1'b1;
    repeat (20) tick(1'b0);
    check("abort_no_pulse", npulse, 0);
    check("abort_dc_after", DC, 0);

    // Enable dropped mid-MEASURE: no result, DC held, then a clean next period.
    measure(2, 14, 1'b1);
    check("pre_enable_dc", p_dc, 8'b0000_0001);
    clear_mon();
    repeat (3) tick(1'b1);
    enable = 1'b0;
    repeat (5) tick(1'b1);
    check("dis_no_pulse", npulse, 0);
    check("dis_dc_held", DC, 8'b0000_0001);
    enable = 1'b1;
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b0);
    for (int n = 0; n < 6 && !seen; n++) begin
      repeat (4) tick(1'b1);
      repeat (12) tick(1'b0);
    end
    check("reen_seen", seen, 1);
    check("reen_dc", p_dc, 8'b0000_0010);
    check("reen_pulses", npulse, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
